seg7_monitor: RTL

SEG7_MONITOR -- requirements
Module: seg7_monitor

---
 rtl/seg7_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seg7_monitor.sv
// Seven-segment debug monitor: four hex value digits, a source digit and a
// hold indicator, with a change-flash decimal point and a blinking hold "H".
module seg7_monitor #(
   parameter int unsigned FLASH_CYCLES = 8,
   parameter int unsigned BLINK_DIV    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [4:0]  sel_led,
   input  logic        hold,
   input  logic        blank_lz,
   output logic [7:0]  HEX0,
   output logic [7:0]  HEX1,
   output logic [7:0]  HEX2,
   output logic [7:0]  HEX3,
   output logic [7:0]  HEX4,
   output logic [7:0]  HEX5
);

   localparam int unsigned FW = $clog2(FLASH_CYCLES + 1);
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);
   localparam logic [BW-1:0] DIV_LAST   = BW'(BLINK_DIV - 1);

   localparam logic [7:0] PAT_BLANK = 8'hFF;
   localparam logic [7:0] PAT_DASH  = 8'hBF;
   localparam logic [7:0] PAT_H     = 8'h89;

   function automatic logic [7:0] seg_hex(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'h0: p = 8'hC0;
         4'h1: p = 8'hF9;
         4'h2: p = 8'hA4;
         4'h3: p = 8'hB0;
         4'h4: p = 8'h99;
         4'h5: p = 8'h92;
         4'h6: p = 8'h82;
         4'h7: p = 8'hF8;
         4'h8: p = 8'h80;
         4'h9: p = 8'h90;
         4'hA: p = 8'h88;
         4'hB: p = 8'h83;
         4'hC: p = 8'hC6;
         4'hD: p = 8'hA1;
         4'hE: p = 8'h86;
         default: p = 8'h8E;
      endcase
      return p;
   endfunction

   logic [15:0]   disp_val;
   logic [4:0]    disp_src;
   logic [FW-1:0] flash_cnt;
   logic [BW-1:0] blink_div;
   logic          blink_ph;

   logic [3:0]    show;
   logic [7:0]    dig_nxt [4];
   logic [7:0]    src_nxt;
   logic [7:0]    hold_nxt;

   // Sample stage: hold wins over a simultaneous value change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_val  <= '0;
         disp_src  <= '0;
         flash_cnt <= '0;
      end else begin
         if (!hold) begin
            disp_val <= value;
            disp_src <= sel_led;
         end
         if (!hold && (value != disp_val))
            flash_cnt <= FLASH_LOAD;
         else if (flash_cnt != '0)
            flash_cnt <= flash_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_div <= '0;
         blink_ph  <= 1'b0;
      end else if (!hold) begin
         blink_div <= '0;
         blink_ph  <= 1'b0;
      end else if (blink_div == DIV_LAST) begin
         blink_div <= '0;
         blink_ph  <= ~blink_ph;
      end else begin
         blink_div <= blink_div + 1'b1;
      end
   end

   // show[i] set when digit i is at or below the most significant nonzero nibble
   always_comb begin
      show[3] = |disp_val[15:12];
      show[2] = show[3] | (|disp_val[11:8]);
      show[1] = show[2] | (|disp_val[7:4]);
      show[0] = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         dig_nxt[i] = (blank_lz && !show[i]) ? PAT_BLANK : seg_hex(disp_val[4*i +: 4]);
      end
      if (flash_cnt != '0)
         dig_nxt[0][7] = 1'b0;

      case (disp_src)
         5'b00001: src_nxt = seg_hex(4'h0);
         5'b00010: src_nxt = seg_hex(4'h1);
         5'b00100: src_nxt = seg_hex(4'h2);
         5'b01000: src_nxt = seg_hex(4'h3);
         5'b10000: src_nxt = seg_hex(4'h4);
         5'b11111: src_nxt = PAT_DASH;
         default:  src_nxt = PAT_BLANK;
      endcase

      // Gate on the live hold level so HEX5 blanks at the release edge itself.
      hold_nxt = (hold && blink_ph) ? PAT_H : PAT_BLANK;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HEX0 <= 8'hC0;
         HEX1 <= PAT_BLANK;
         HEX2 <= PAT_BLANK;
         HEX3 <= PAT_BLANK;
         HEX4 <= PAT_BLANK;
         HEX5 <= PAT_BLANK;
      end else begin
         HEX0 <= dig_nxt[0];
         HEX1 <= dig_nxt[1];
         HEX2 <= dig_nxt[2];
         HEX3 <= dig_nxt[3];
         HEX4 <= src_nxt;
         HEX5 <= hold_nxt;
      end
   end

endmodule
